// File: rtl/double_saturation_clip.sv
// Symmetric two-sided clamp for a signed sample stream.
// The input is limited to [-MAX_VAL, +MAX_VAL] and registered once.
// Two flags report which rail was hit on that sample, for overflow monitoring.
module double_saturation_clip #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_VAL    = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         sat_pos,
  output logic                         sat_neg
);

  // The compare runs one bit wider than the data, so both rails and the most
  // negative input code are representable without overflow or wrap.
  localparam int EXT_W = DATA_WIDTH + 1;
  localparam int MAX_LEGAL = (2 ** (DATA_WIDTH - 1)) - 1;

  localparam logic signed [EXT_W-1:0] RAIL_POS = $signed(EXT_W'(MAX_VAL));
  localparam logic signed [EXT_W-1:0] RAIL_NEG = -RAIL_POS;

  // A rail outside the signed range of the data cannot be represented on
  // dout, so such a configuration is rejected at elaboration.
  if (MAX_VAL < 0 || MAX_VAL > MAX_LEGAL) begin : g_bad_max_val
    $error("double_saturation_clip: MAX_VAL=%0d outside 0..%0d for DATA_WIDTH=%0d",
           MAX_VAL, MAX_LEGAL, DATA_WIDTH);
  end

  // Sign-extend a data-width sample into the compare width.
  function automatic logic signed [EXT_W-1:0] sign_extend(
    input logic signed [DATA_WIDTH-1:0] x
  );
    return {x[DATA_WIDTH-1], x};
  endfunction

  // Saturate a compare-width value onto the rails and narrow it back to the
  // data width; inside the rails the low bits are the original sample.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(
    input logic signed [EXT_W-1:0] x
  );
    logic signed [EXT_W-1:0] y;
    if (x > RAIL_POS) begin
      y = RAIL_POS;
    end else if (x < RAIL_NEG) begin
      y = RAIL_NEG;
    end else begin
      y = x;
    end
    return y[DATA_WIDTH-1:0];
  endfunction

  logic signed [EXT_W-1:0]      din_ext_p0;
  logic                         above_p0;
  logic                         below_p0;
  logic signed [DATA_WIDTH-1:0] clip_p0;

  logic signed [DATA_WIDTH-1:0] dout_p1;
  logic                         sat_pos_p1;
  logic                         sat_neg_p1;

  // Stage p0: combinational rail compare and clamp of the incoming sample.
  always_comb begin
    din_ext_p0 = sign_extend(din);
    above_p0   = (din_ext_p0 > RAIL_POS);
    below_p0   = (din_ext_p0 < RAIL_NEG);
    clip_p0    = saturate(din_ext_p0);
  end

  // Stage p1: single output register; reset forces a zero sample, no flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p1    <= '0;
      sat_pos_p1 <= 1'b0;
      sat_neg_p1 <= 1'b0;
    end else begin
      dout_p1    <= clip_p0;
      sat_pos_p1 <= above_p0;
      sat_neg_p1 <= below_p0;
    end
  end

  assign dout    = dout_p1;
  assign sat_pos = sat_pos_p1;
  assign sat_neg = sat_neg_p1;

endmodule

// File: tb/tb_double_saturation_clip.sv
// Directed bench for double_saturation_clip: three instances (MAX_VAL = 15,
// 127, 0) share one input stream; expected results are queued when a sample
// is driven and compared one clock later, when the register has captured it.
module tb_double_saturation_clip;

  logic              clk;
  logic              rst;
  logic signed [7:0] din;

  logic signed [7:0] dout_15, dout_127, dout_0;
  logic              pos_15, pos_127, pos_0;
  logic              neg_15, neg_127, neg_0;

  int tests;
  int fails;

  typedef struct {
    logic signed [7:0] dout;
    logic              pos;
    logic              neg;
  } res_t;

  typedef struct {
    string tag;
    res_t  r15;
    res_t  r127;
    res_t  r0;
  } exp_t;

  exp_t sb[$];

  double_saturation_clip #(.DATA_WIDTH(8), .MAX_VAL(15)) dut_15 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout_15), .sat_pos(pos_15), .sat_neg(neg_15)
  );

  double_saturation_clip #(.DATA_WIDTH(8), .MAX_VAL(127)) dut_127 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout_127), .sat_pos(pos_127), .sat_neg(neg_127)
  );

  double_saturation_clip #(.DATA_WIDTH(8), .MAX_VAL(0)) dut_0 (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout_0), .sat_pos(pos_0), .sat_neg(neg_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference clamp in plain integer arithmetic.
  function automatic res_t model(input int d, input int mx, input bit r);
    res_t e;
    int   v;
    e.pos = 1'b0;
    e.neg = 1'b0;
    if (r) begin
      v = 0;
    end else if (d > mx) begin
      v = mx;
      e.pos = 1'b1;
    end else if (d < -mx) begin
      v = -mx;
      e.neg = 1'b1;
    end else begin
      v = d;
    end
    e.dout = 8'(v);
    return e;
  endfunction

  task automatic check_one(input string tag, input string inst,
                           input res_t got, input res_t exp);
    tests++;
    assert (got.dout === exp.dout) else begin
      fails++;
      $error("FAIL %s/%s dout: got %0d, expected %0d", tag, inst, got.dout, exp.dout);
    end
    tests++;
    assert (got.pos === exp.pos) else begin
      fails++;
      $error("FAIL %s/%s sat_pos: got %b, expected %b", tag, inst, got.pos, exp.pos);
    end
    tests++;
    assert (got.neg === exp.neg) else begin
      fails++;
      $error("FAIL %s/%s sat_neg: got %b, expected %b", tag, inst, got.neg, exp.neg);
    end
  endtask

  // Compare the oldest queued expectation against the registered outputs.
  task automatic compare_front();
    exp_t e;
    res_t g;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    g.dout = dout_15;  g.pos = pos_15;  g.neg = neg_15;
    check_one(e.tag, "mv15", g, e.r15);
    g.dout = dout_127; g.pos = pos_127; g.neg = neg_127;
    check_one(e.tag, "mv127", g, e.r127);
    g.dout = dout_0;   g.pos = pos_0;   g.neg = neg_0;
    check_one(e.tag, "mv0", g, e.r0);
  endtask

  // One clock: on the falling edge check last cycle's result, then drive the
  // next sample and queue what the next rising edge must produce.
  task automatic step(input int d, input bit r, input string tag);
    exp_t e;
    @(negedge clk);
    compare_front();
    din = 8'(d);
    rst = r;
    e.tag  = tag;
    e.r15  = model(d, 15, r);
    e.r127 = model(d, 127, r);
    e.r0   = model(d, 0, r);
    sb.push_back(e);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    din = '0;

    // Reset holds the outputs at zero even with an out-of-range input.
    step(37, 1'b1, "reset0");
    step(37, 1'b1, "reset1");
    step(37, 1'b0, "release");

    // Steady stream and a single overshoot.
    for (int i = 0; i < 10; i++) step(1, 1'b0, "hold1");
    step(18, 1'b0, "over18");
    step(1, 1'b0, "back1");
    step(0, 1'b0, "zero");
    step(-1, 1'b0, "neg1");
    step(-2, 1'b0, "neg2");

    // Exact rails pass, one past the rails clamps.
    step(15, 1'b0, "rail_p");
    step(16, 1'b0, "over_p");
    step(-15, 1'b0, "rail_n");
    step(-16, 1'b0, "over_n");

    // Extreme codes must not wrap.
    step(127, 1'b0, "max_code");
    step(-128, 1'b0, "min_code");

    // Reset asserted mid-stream, then released with the same input.
    step(-100, 1'b1, "mid_rst");
    step(-100, 1'b0, "post_rst");

    // Points aimed at the wide-rail and zero-rail instances.
    step(1, 1'b0, "unit_p");
    step(-1, 1'b0, "unit_n");
    step(-127, 1'b0, "m127");
    step(126, 1'b0, "p126");
    step(-128, 1'b0, "min_again");
    step(0, 1'b0, "zero_end");

    // Drain the last queued expectation.
    @(negedge clk);
    compare_front();

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
